// File: rtl/sdram_arb_if.sv
// Requester and SDRAM-controller signal bundle for the two-port arbiter.
// master drives requests and controller responses; slave is the arbiter.
interface sdram_arb_if #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 10,
  parameter int DATA_W = 16
);
  logic              i_m0_req;
  logic              i_m0_we;
  logic [ADDR_W-1:0] i_m0_addr;
  logic [LEN_W-1:0]  i_m0_len;
  logic [DATA_W-1:0] i_m0_wdata;
  logic [DATA_W-1:0] o_m0_rdata;
  logic              o_m0_grant;
  logic              o_m0_valid;
  logic              o_m0_done;

  logic              i_m1_req;
  logic              i_m1_we;
  logic [ADDR_W-1:0] i_m1_addr;
  logic [LEN_W-1:0]  i_m1_len;
  logic [DATA_W-1:0] i_m1_wdata;
  logic [DATA_W-1:0] o_m1_rdata;
  logic              o_m1_grant;
  logic              o_m1_valid;
  logic              o_m1_done;

  logic [ADDR_W-1:0] o_ram_addr;
  logic [LEN_W-1:0]  o_ram_len;
  logic              o_ram_read_req;
  logic              o_ram_write_req;
  logic [DATA_W-1:0] o_ram_data;
  logic [DATA_W-1:0] i_ram_data;
  logic              i_ram_read_valid;
  logic              i_ram_write_valid;
  logic              i_ram_ready;

  modport master (
    output i_m0_req, i_m0_we, i_m0_addr,
    output i_m0_len, i_m0_wdata,
    input  o_m0_rdata, o_m0_grant,
    input  o_m0_valid, o_m0_done,
    output i_m1_req, i_m1_we, i_m1_addr,
    output i_m1_len, i_m1_wdata,
    input  o_m1_rdata, o_m1_grant,
    input  o_m1_valid, o_m1_done,
    input  o_ram_addr, o_ram_len,
    input  o_ram_read_req, o_ram_write_req,
    input  o_ram_data,
    output i_ram_data, i_ram_read_valid,
    output i_ram_write_valid, i_ram_ready
  );

  modport slave (
    input  i_m0_req, i_m0_we, i_m0_addr,
    input  i_m0_len, i_m0_wdata,
    output o_m0_rdata, o_m0_grant,
    output o_m0_valid, o_m0_done,
    input  i_m1_req, i_m1_we, i_m1_addr,
    input  i_m1_len, i_m1_wdata,
    output o_m1_rdata, o_m1_grant,
    output o_m1_valid, o_m1_done,
    output o_ram_addr, o_ram_len,
    output o_ram_read_req, o_ram_write_req,
    output o_ram_data,
    input  i_ram_data, i_ram_read_valid,
    input  i_ram_write_valid, i_ram_ready
  );
endinterface

// File: rtl/sdram_arb.sv
// Two-requester round-robin burst arbiter in front of an SDRAM
// controller user port; one burst in flight, up to one page long.
module sdram_arb #(
  parameter int ADDR_W = 24,
  parameter int LEN_W  = 10,
  parameter int DATA_W = 16
) (
  input logic        i_clk,
  input logic        i_rst_n,
  sdram_arb_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_XFER,
    S_DONE
  } state_t;

  localparam int MAXL = 1 << (LEN_W - 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAXL);

  state_t            r_state;
  state_t            w_next;
  logic              r_owner;
  logic              r_prio;
  logic              r_we;
  logic [LEN_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;

  logic              w_any;
  logic              w_win;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [LEN_W-1:0]  w_win_len;
  logic [LEN_W-1:0]  w_clamp;
  logic              w_start;
  logic              w_act;
  logic              w_beat;
  logic              w_last;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_rreq;
  logic              w_wreq;
  logic              w_valid0;
  logic              w_valid1;
  logic              w_done0;
  logic              w_done1;

  // Winner: priority pointer breaks ties, otherwise the lone requester.
  always_comb begin
    w_any      = bus.i_m0_req | bus.i_m1_req;
    w_win      = (bus.i_m0_req & bus.i_m1_req)
               ? r_prio : bus.i_m1_req;
    w_win_we   = w_win ? bus.i_m1_we : bus.i_m0_we;
    w_win_addr = w_win ? bus.i_m1_addr : bus.i_m0_addr;
    w_win_len  = w_win ? bus.i_m1_len : bus.i_m0_len;
    w_clamp    = (w_win_len > MAX_LEN) ? MAX_LEN : w_win_len;
  end

  always_comb begin
    w_start = i_rst_n & (r_state == S_IDLE)
            & bus.i_ram_ready & w_any;
    w_act   = (r_state == S_ISSUE) | (r_state == S_XFER);
    w_beat  = w_act & (r_we ? bus.i_ram_write_valid
                            : bus.i_ram_read_valid);
    w_last  = w_beat & ((r_cnt + LEN_W'(1)) == r_len);
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start)
          w_next = (w_clamp == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (w_beat)
          w_next = w_last ? S_DONE : S_XFER;
      end
      S_XFER: begin
        if (w_last)
          w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_grant0 = w_start & ~w_win;
    w_grant1 = w_start & w_win;
    w_rreq   = (r_state == S_ISSUE) & ~r_we;
    w_wreq   = (r_state == S_ISSUE) & r_we;
    w_valid0 = w_beat & ~r_owner;
    w_valid1 = w_beat & r_owner;
    w_done0  = (r_state == S_DONE) & ~r_owner;
    w_done1  = (r_state == S_DONE) & r_owner;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner <= 1'b0;
      r_prio  <= 1'b0;
      r_we    <= 1'b0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
    end else begin
      if (w_start) begin
        r_owner <= w_win;
        r_we    <= w_win_we;
        r_addr  <= w_win_addr;
        r_len   <= w_clamp;
        r_cnt   <= '0;
      end else if (w_beat) begin
        r_cnt   <= r_cnt + LEN_W'(1);
      end
      if (r_state == S_DONE)
        r_prio <= ~r_owner;
    end
  end

  assign bus.o_m0_grant      = w_grant0;
  assign bus.o_m1_grant      = w_grant1;
  assign bus.o_m0_valid      = w_valid0;
  assign bus.o_m1_valid      = w_valid1;
  assign bus.o_m0_done       = w_done0;
  assign bus.o_m1_done       = w_done1;
  assign bus.o_m0_rdata      = bus.i_ram_data;
  assign bus.o_m1_rdata      = bus.i_ram_data;
  assign bus.o_ram_addr      = r_addr;
  assign bus.o_ram_len       = r_len;
  assign bus.o_ram_read_req  = w_rreq;
  assign bus.o_ram_write_req = w_wreq;
  assign bus.o_ram_data      = r_owner ? bus.i_m1_wdata
                                       : bus.i_m0_wdata;

endmodule

// File: tb/tb_sdram_arb.sv
// Directed plus randomized bursts against a transaction-level model
// of the arbiter (winner, clamped length, beat count, done timing).
module tb_sdram_arb;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  bit   m_prio;

  sdram_arb_if #(
    .ADDR_W(24), .LEN_W(10), .DATA_W(16)
  ) bus ();

  sdram_arb #(
    .ADDR_W(24), .LEN_W(10), .DATA_W(16)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_g0"}, 32'(bus.o_m0_grant), 0);
    chk({tag, "_g1"}, 32'(bus.o_m1_grant), 0);
    chk({tag, "_rr"}, 32'(bus.o_ram_read_req), 0);
    chk({tag, "_wr"}, 32'(bus.o_ram_write_req), 0);
    chk({tag, "_v0"}, 32'(bus.o_m0_valid), 0);
    chk({tag, "_v1"}, 32'(bus.o_m1_valid), 0);
  endtask

  task automatic do_burst(input bit r0, input bit r1,
                          input bit we,
                          input logic [23:0] addr,
                          input int len, input int gap,
                          input int rdy_wait);
    bit win;
    int exp_len;
    int beats;
    int cyc;
    bit v;
    bit wv;
    logic [23:0] a1;
    logic [15:0] wd0;
    logic [15:0] wd1;
    logic [15:0] rd;
    a1 = addr ^ 24'h800000;
    win = (r0 && r1) ? m_prio : r1;
    exp_len = (len > 512) ? 512 : len;
    bus.i_m0_req = r0;
    bus.i_m1_req = r1;
    bus.i_m0_we = we;
    bus.i_m1_we = we;
    bus.i_m0_addr = addr;
    bus.i_m1_addr = a1;
    bus.i_m0_len = 10'(len);
    bus.i_m1_len = 10'(len);
    bus.i_ram_ready = 1'b0;
    for (int k = 0; k < rdy_wait; k++) begin
      #1;
      chk_quiet("notready");
      @(negedge clk);
    end
    bus.i_ram_ready = 1'b1;
    #1;
    chk("grant0", 32'(bus.o_m0_grant), 32'(!win));
    chk("grant1", 32'(bus.o_m1_grant), 32'(win));
    chk("grant_rr", 32'(bus.o_ram_read_req), 0);
    chk("grant_wr", 32'(bus.o_ram_write_req), 0);
    @(negedge clk);
    if (win) bus.i_m1_req = 1'b0;
    else bus.i_m0_req = 1'b0;
    chk("ram_addr", 32'(bus.o_ram_addr),
        32'(win ? a1 : addr));
    chk("ram_len", 32'(bus.o_ram_len), exp_len);
    beats = 0;
    cyc = 0;
    while (beats < exp_len && cyc < 4000) begin
      v = ($urandom_range(99) >= gap);
      wv = ($urandom_range(3) == 0);
      wd0 = 16'($urandom);
      wd1 = 16'($urandom);
      rd = 16'($urandom);
      bus.i_m0_wdata = wd0;
      bus.i_m1_wdata = wd1;
      bus.i_ram_data = rd;
      bus.i_ram_read_valid = we ? wv : v;
      bus.i_ram_write_valid = we ? v : wv;
      #1;
      chk("rreq", 32'(bus.o_ram_read_req),
          32'(!we && beats == 0));
      chk("wreq", 32'(bus.o_ram_write_req),
          32'(we && beats == 0));
      chk("valid0", 32'(bus.o_m0_valid), 32'(v && !win));
      chk("valid1", 32'(bus.o_m1_valid), 32'(v && win));
      chk("xfer_g", 32'({bus.o_m0_grant, bus.o_m1_grant}), 0);
      chk("xfer_d", 32'({bus.o_m0_done, bus.o_m1_done}), 0);
      if (we)
        chk("wdata", 32'(bus.o_ram_data),
            32'(win ? wd1 : wd0));
      else begin
        chk("rdata0", 32'(bus.o_m0_rdata), 32'(rd));
        chk("rdata1", 32'(bus.o_m1_rdata), 32'(rd));
      end
      @(negedge clk);
      if (v) beats++;
      cyc++;
    end
    chk("beats", beats, exp_len);
    bus.i_ram_read_valid = 1'b1;
    bus.i_ram_write_valid = 1'b1;
    #1;
    chk("done0", 32'(bus.o_m0_done), 32'(!win));
    chk("done1", 32'(bus.o_m1_done), 32'(win));
    chk_quiet("donecyc");
    @(negedge clk);
    bus.i_ram_read_valid = 1'b0;
    bus.i_ram_write_valid = 1'b0;
    m_prio = !win;
  endtask

  initial begin
    bit r0;
    bit r1;
    n_chk = 0;
    n_fail = 0;
    m_prio = 1'b0;
    clk = 1'b0;
    rst_n = 1'b0;
    bus.i_m0_req = 1'b1;
    bus.i_m1_req = 1'b1;
    bus.i_m0_we = 1'b0;
    bus.i_m1_we = 1'b0;
    bus.i_m0_addr = '0;
    bus.i_m1_addr = '0;
    bus.i_m0_len = 10'd4;
    bus.i_m1_len = 10'd4;
    bus.i_m0_wdata = '0;
    bus.i_m1_wdata = '0;
    bus.i_ram_data = '0;
    bus.i_ram_read_valid = 1'b0;
    bus.i_ram_write_valid = 1'b0;
    bus.i_ram_ready = 1'b1;
    #1;
    chk_quiet("rst");
    chk("rst_addr", 32'(bus.o_ram_addr), 0);
    chk("rst_len", 32'(bus.o_ram_len), 0);
    chk("rst_d", 32'({bus.o_m0_done, bus.o_m1_done}), 0);
    @(negedge clk);
    bus.i_m0_req = 1'b0;
    bus.i_m1_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_burst(1, 1, 0, 24'h000100, 3, 20, 0);
    do_burst(1, 1, 1, 24'h000140, 5, 30, 0);
    do_burst(1, 1, 0, 24'h000180, 2, 0, 0);
    do_burst(1, 0, 1, 24'h000200, 4, 0, 0);
    do_burst(0, 1, 0, 24'h001000, 512, 30, 0);
    do_burst(1, 0, 0, 24'h002000, 0, 0, 0);
    do_burst(0, 1, 1, 24'h003000, 700, 10, 0);
    do_burst(1, 1, 1, 24'h004000, 6, 25, 3);
    do_burst(1, 1, 0, 24'h005000, 1, 40, 2);

    for (int i = 0; i < 8; i++) begin
      r0 = 1'($urandom_range(1));
      r1 = r0 ? 1'($urandom_range(1)) : 1'b1;
      do_burst(r0, r1, 1'($urandom_range(1)),
               24'($urandom), $urandom_range(40),
               $urandom_range(50), $urandom_range(2));
    end

    do_burst(1, 0, 0, 24'h006000, 2, 0, 0);
    bus.i_m0_req = 1'b1;
    bus.i_m0_we = 1'b0;
    bus.i_m0_addr = 24'h007000;
    bus.i_m0_len = 10'd8;
    bus.i_ram_ready = 1'b1;
    #1;
    chk("rb_grant", 32'(bus.o_m0_grant), 1);
    @(negedge clk);
    bus.i_m0_req = 1'b0;
    bus.i_ram_read_valid = 1'b1;
    #1;
    chk("rb_rreq", 32'(bus.o_ram_read_req), 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rb_v3", 32'(bus.o_m0_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("rb_rst");
    chk("rb_addr", 32'(bus.o_ram_addr), 0);
    chk("rb_len", 32'(bus.o_ram_len), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("rb_done",
          32'({bus.o_m0_done, bus.o_m1_done}), 0);
    end
    bus.i_ram_read_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_prio = 1'b0;
    @(negedge clk);
    do_burst(1, 1, 1, 24'h008000, 3, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arb.md
SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 Parameter ADDR_W, default 24, SHALL set the linear address width (bank+row+col).
REQ-002 Parameter LEN_W, default 10, SHALL set the burst-length width; max legal length is 2**(LEN_W-1) = 512 (one page).
REQ-003 Parameter DATA_W, default 16, SHALL set the data width.
REQ-004 i_clk  in  1  SHALL be the single clock; the SDRAM controller user side runs on the same clock.
REQ-005 i_rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 i_mN_req  in  1  (N=0,1) SHALL be the level request from requester N; held high until o_mN_done.
REQ-007 i_mN_we  in  1  SHALL be 1 for write and 0 for read, valid while i_mN_req is high.
REQ-008 i_mN_addr  in  ADDR_W  SHALL be the burst start address; i_mN_len  in  LEN_W  SHALL be the burst word count.
REQ-009 i_mN_wdata  in  DATA_W  SHALL be the current write word; o_mN_rdata  out  DATA_W  SHALL be the read word.
REQ-010 o_mN_grant  out  1  SHALL be a one-cycle pulse when requester N wins arbitration.
REQ-011 o_mN_valid  out  1  SHALL be a per-beat strobe: read word present, or write word consumed.
REQ-012 o_mN_done  out  1  SHALL be a one-cycle pulse at the end of requester N's burst.
REQ-013 Controller side: o_ram_addr ADDR_W, o_ram_len LEN_W, o_ram_read_req 1, o_ram_write_req 1, o_ram_data DATA_W outputs; i_ram_data DATA_W, i_ram_read_valid 1, i_ram_write_valid 1, i_ram_ready 1 inputs.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE, XFER, DONE.
REQ-015 IDLE: when i_ram_ready=1 and any i_mN_req=1, SHALL select a requester, latch its addr/len/we into o_ram_addr/o_ram_len/internal we, pulse its o_mN_grant, and enter ISSUE on the next cycle.
REQ-016 Arbitration SHALL be round-robin: on simultaneous requests the requester that was not served last wins; after reset, requester 0 has priority.
REQ-017 A request with len=0 SHALL skip ISSUE/XFER: IDLE -> DONE, no controller request, done pulse the following cycle.
REQ-018 A len above 512 SHALL be clamped to 512 at latch time.
REQ-019 ISSUE: SHALL assert o_ram_write_req (we=1) or o_ram_read_req (we=0), never both, until the first matching valid, then deassert on the next edge and go to XFER (or DONE if len=1).
REQ-020 Beat counter (LEN_W bits) SHALL clear on grant and increment on each matching i_ram_*_valid in ISSUE/XFER; the valid making count equal len SHALL move the FSM to DONE.
REQ-021 o_mN_valid SHALL equal the matching controller valid combinationally, gated by grant owner and state in {ISSUE, XFER}; the non-granted requester's valid SHALL stay 0.
REQ-022 o_ram_data SHALL be a combinational mux of the granted requester's i_mN_wdata; o_mN_rdata SHALL pass i_ram_data to both requesters unregistered.
REQ-023 Valids of the wrong type, or arriving in IDLE/DONE, SHALL be ignored and not counted.
REQ-024 DONE: SHALL pulse o_mN_done for the owner, update the round-robin pointer, return to IDLE; a new grant is possible no earlier than the cycle after DONE.
REQ-025 A requester dropping i_mN_req mid-burst SHALL NOT abort the burst; it runs to len beats.
REQ-026 Request latency: from i_mN_req high in IDLE with ready high, grant SHALL pulse in the same cycle and the controller request SHALL rise on the next edge.

Reset
REQ-027 On i_rst_n=0 asynchronously: FSM=IDLE, RR pointer=requester 0, beat counter=0, all grant/valid/done outputs=0, o_ram_read_req=o_ram_write_req=0, o_ram_addr=0, o_ram_len=0.
REQ-028 Reset asserted mid-burst SHALL drop controller requests immediately; no done pulse SHALL be issued for the aborted burst.

Verification
REQ-029 m0 write, addr 0x000200, len 4, controller valid every cycle -> one write_req pulse train, 4 o_m0_valid, o_m0_done 1 cycle after 4th valid.
REQ-030 m0 and m1 request simultaneously after reset -> m0 granted first, m1 granted immediately after m0 done; repeat -> m1 then m0 does not occur until each is served once.
REQ-031 m1 read, len 512, valids with random gaps -> exactly 512 o_m1_valid, o_m1_rdata matches i_ram_data each beat, o_m0_valid stays 0.
REQ-032 m0 len=0 -> grant then done within 2 cycles, o_ram_*_req never asserted; len=700 -> o_ram_len=512.
REQ-033 i_ram_ready=0 with pending requests -> no grant; ready rises -> grant same cycle.
REQ-034 i_rst_n low at beat 3 of a len-8 read -> req lines 0 immediately, FSM IDLE, no done; after release m0 has priority.
